// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv: dual-motor H-bridge PWM driver.
// Each wheel has a forward and a reverse leg. Duty is taken from the signed
// speed command, sampled once per period. Every period starts with DEAD_CYC
// clocks of all-low. A single over-current event blanks all legs for the rest
// of the period.
// Optional feature: define MTR_PWM_FLT_LATCH_EN to latch a fault after
// FLT_CNT consecutive blanked periods. Without it, fault is tied low.
module mtr_pwm_drv #(
    parameter int PWM_W    = 11,
    parameter int DEAD_CYC = 8,
    parameter int FLT_CNT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [11:0] lft_spd,
    input  logic signed [11:0] rght_spd,
    input  logic               en,
    input  logic               ovr_curr,
    output logic               lft_fwd,
    output logic               lft_rev,
    output logic               rght_fwd,
    output logic               rght_rev,
    output logic               prd_tick,
    output logic               fault
);

    localparam int MAG_W = 11;
    // The pulse end is one bit wider than the counter, so a long pulse runs
    // into the period end and is cut there instead of wrapping.
    localparam int BND_W = ((PWM_W > MAG_W) ? PWM_W : MAG_W) + 1;

`ifdef MTR_PWM_FLT_LATCH_EN
    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_FAULT} state_t;
    localparam int FC_W = $clog2(FLT_CNT + 1);
    logic [FC_W-1:0] flt_cnt;
`else
    typedef enum logic {ST_OFF, ST_RUN} state_t;
`endif

    state_t           state;
    logic [PWM_W-1:0] cnt;
    logic [MAG_W-1:0] lft_mag;
    logic [MAG_W-1:0] rght_mag;
    logic             lft_dir;
    logic             rght_dir;
    logic             blank;
    logic             wrap;
    logic             drive_ok;
    logic             lft_on;
    logic             rght_on;

    // The magnitude saturates to 2047, so -2048 gives the same duty as +2047.
    function automatic logic [MAG_W-1:0] sat_mag(input logic signed [11:0] spd);
        logic [11:0] neg;
        neg = 12'(-spd);
        if (!spd[11])
            return spd[10:0];
        if (spd[10:0] == 11'd0)
            return 11'h7FF;
        return neg[10:0];
    endfunction

    // The leg is active from DEAD_CYC up to DEAD_CYC+mag (exclusive).
    function automatic logic in_window(input logic [PWM_W-1:0] c,
                                       input logic [MAG_W-1:0] m);
        logic [BND_W-1:0] cw;
        logic [BND_W-1:0] lo;
        logic [BND_W-1:0] hi;
        cw = BND_W'(c);
        lo = BND_W'(DEAD_CYC);
        hi = lo + BND_W'(m);
        return (cw >= lo) && (cw < hi);
    endfunction

    assign wrap     = &cnt;
    assign prd_tick = wrap;

    // ovr_curr gates the legs in the same cycle that it sets blank.
    // The legs therefore drop at the same edge where blank rises.
    assign drive_ok = (state == ST_RUN) && en && !blank && !ovr_curr;
    assign lft_on   = drive_ok && in_window(cnt, lft_mag);
    assign rght_on  = drive_ok && in_window(cnt, rght_mag);

`ifndef MTR_PWM_FLT_LATCH_EN
    assign fault = 1'b0;
`endif

    // Free-running period counter; it runs in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt + PWM_W'(1);
    end

    // Shadow duty and direction are captured in the last cycle of the period.
    // Capture also runs in OFF, so RUN starts with a fresh command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_mag  <= '0;
            rght_mag <= '0;
            lft_dir  <= 1'b0;
            rght_dir <= 1'b0;
        end else if (wrap) begin
            lft_mag  <= sat_mag(lft_spd);
            rght_mag <= sat_mag(rght_spd);
            lft_dir  <= lft_spd[11];
            rght_dir <= rght_spd[11];
        end
    end

    // Drive state machine, blanking flag and registered leg outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            blank    <= 1'b0;
            lft_fwd  <= 1'b0;
            lft_rev  <= 1'b0;
            rght_fwd <= 1'b0;
            rght_rev <= 1'b0;
`ifdef MTR_PWM_FLT_LATCH_EN
            fault    <= 1'b0;
            flt_cnt  <= '0;
`endif
        end else begin
            lft_fwd  <= lft_on  & ~lft_dir;
            lft_rev  <= lft_on  &  lft_dir;
            rght_fwd <= rght_on & ~rght_dir;
            rght_rev <= rght_on &  rght_dir;

            if (wrap || (state != ST_RUN) || !en)
                blank <= 1'b0;
            else if (ovr_curr)
                blank <= 1'b1;

            case (state)
                ST_OFF: begin
                    if (wrap && en)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!en) begin
                        state <= ST_OFF;
`ifdef MTR_PWM_FLT_LATCH_EN
                        flt_cnt <= '0;
                    end else if (wrap) begin
                        if (blank || ovr_curr) begin
                            if (flt_cnt >= FC_W'(FLT_CNT - 1)) begin
                                state <= ST_FAULT;
                                fault <= 1'b1;
                            end else begin
                                flt_cnt <= flt_cnt + FC_W'(1);
                            end
                        end else begin
                            flt_cnt <= '0;
                        end
`endif
                    end
                end
`ifdef MTR_PWM_FLT_LATCH_EN
                ST_FAULT: begin
                    if (!en) begin
                        state   <= ST_OFF;
                        fault   <= 1'b0;
                        flt_cnt <= '0;
                    end
                end
`endif
                default: state <= ST_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// tb_mtr_pwm_drv: scoreboard bench for mtr_pwm_drv in its default build.
// At the start of each period, the stimulus pushes the expected high-time per
// leg. The monitor pops one entry for every observed period.
`timescale 1ns/1ps
module tb_mtr_pwm_drv;

    localparam int PER  = 2048;
    localparam int DEAD = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [11:0] lft_spd = '0;
    logic signed [11:0] rght_spd = '0;
    logic               en = 1'b0;
    logic               ovr_curr = 1'b0;
    logic               lft_fwd, lft_rev, rght_fwd, rght_rev, prd_tick, fault;

    mtr_pwm_drv #(.PWM_W(11), .DEAD_CYC(DEAD), .FLT_CNT(4)) dut (
        .clk(clk), .rst_n(rst_n), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .en(en), .ovr_curr(ovr_curr), .lft_fwd(lft_fwd), .lft_rev(lft_rev),
        .rght_fwd(rght_fwd), .rght_rev(rght_rev), .prd_tick(prd_tick), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct { int lf; int lr; int rf; int rr; } exp_t;
    // Per-period stimulus. l/r are the commands present at the wrap.
    // ps is the phase where they are applied; with decoy set, their negation
    // is applied first at ps/2. en keeps its old value until pd, is 0 from pd
    // until pr, and is 1 from pr. ovr_curr pulses at po. PER means never.
    typedef struct {
        logic signed [11:0] l;
        logic signed [11:0] r;
        bit decoy;
        int ps; int pd; int pr; int po;
    } prd_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_on  = 1'b0;

    bit                 m_run   = 1'b0;
    bit                 en_prev = 1'b0;
    logic signed [11:0] cap_l   = '0;
    logic signed [11:0] cap_r   = '0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // High-time of the active leg. Evaluation starts at DEAD, ends at the
    // pulse end or the period end, and is cut by en drop or over-current.
    function automatic int pulse(input logic signed [11:0] s, input int cut);
        int mag, hi;
        mag = (s < 0) ? -int'(s) : int'(s);
        if (mag > 2047) mag = 2047;
        hi = DEAD + mag;
        if (hi > PER) hi = PER;
        if (hi > cut) hi = cut;
        return (hi > DEAD) ? hi - DEAD : 0;
    endfunction

    function automatic prd_t mk(input logic signed [11:0] l, input logic signed [11:0] r,
                                input bit d, input int ps, input int pd, input int pr,
                                input int po);
        prd_t p;
        p.l = l; p.r = r; p.decoy = d; p.ps = ps; p.pd = pd; p.pr = pr; p.po = po;
        return p;
    endfunction

    task automatic run_period(input prd_t p);
        exp_t e;
        int   cut;
        e = '{0, 0, 0, 0};
        cut = PER;
        if (p.pd < cut) cut = p.pd;
        if (p.po < cut) cut = p.po;
        if (m_run) begin
            if (cap_l < 0) e.lr = pulse(cap_l, cut); else e.lf = pulse(cap_l, cut);
            if (cap_r < 0) e.rr = pulse(cap_r, cut); else e.rf = pulse(cap_r, cut);
        end
        exp_q.push_back(e);
        for (int ph = 0; ph < PER; ph++) begin
            en = (ph < p.pd) ? en_prev : ((ph < p.pr) ? 1'b0 : 1'b1);
            ovr_curr = (ph == p.po);
            if (p.decoy && ph == p.ps / 2) begin
                lft_spd  = -p.l;
                rght_spd = -p.r;
            end
            if (ph == p.ps) begin
                lft_spd  = p.l;
                rght_spd = p.r;
            end
            if (ph == PER - 1) begin
                en_prev = en;
                cap_l   = lft_spd;
                cap_r   = rght_spd;
            end
            @(posedge clk); #1;
        end
        m_run = en_prev;
    endtask

    int pos = 0, gap = 0, win = 0;
    int c_lf = 0, c_lr = 0, c_rf = 0, c_rr = 0, ovl = 0, dead = 0, flt = 0;
    bit tick_prev = 1'b0, seen_tick = 1'b0;

    // Monitor: a period's pulses end at the cycle after prd_tick (output latency).
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            c_lf += int'(lft_fwd);  c_lr += int'(lft_rev);
            c_rf += int'(rght_fwd); c_rr += int'(rght_rev);
            if ((lft_fwd && lft_rev) || (rght_fwd && rght_rev)) ovl++;
            if (pos >= 1 && pos <= DEAD && (lft_fwd || lft_rev || rght_fwd || rght_rev)) dead++;
            if (fault) flt++;
            gap++;
            if (tick_prev) begin
                check($sformatf("win%0d exp_avail", win), int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("win%0d lft_fwd_cycles", win),  c_lf, e.lf);
                    check($sformatf("win%0d lft_rev_cycles", win),  c_lr, e.lr);
                    check($sformatf("win%0d rght_fwd_cycles", win), c_rf, e.rf);
                    check($sformatf("win%0d rght_rev_cycles", win), c_rr, e.rr);
                end
                check($sformatf("win%0d leg_overlap", win), ovl, 0);
                check($sformatf("win%0d dead_time_high", win), dead, 0);
                check($sformatf("win%0d fault_high", win), flt, 0);
                c_lf = 0; c_lr = 0; c_rf = 0; c_rr = 0; ovl = 0; dead = 0; flt = 0;
                win++;
            end
            if (prd_tick) begin
                if (seen_tick) check("tick_gap", gap, PER);
                gap = 0;
                seen_tick = 1'b1;
            end
            tick_prev = prd_tick;
            pos = prd_tick ? 0 : pos + 1;
        end
    end

    initial begin
        prd_t p;
        prd_t dir_q[$];

        repeat (3) @(posedge clk);
        #1;
        check("rst lft_fwd", lft_fwd, 0);
        check("rst lft_rev", lft_rev, 0);
        check("rst rght_fwd", rght_fwd, 0);
        check("rst rght_rev", rght_rev, 0);
        check("rst prd_tick", prd_tick, 0);
        check("rst fault", fault, 0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        dir_q.push_back(mk( 12'sh100, -12'sh100, 1'b0,   20,   0,   5, PER));
        dir_q.push_back(mk( 12'sh7FF,  12'sh800, 1'b0, 1000, PER, PER, PER));
        dir_q.push_back(mk( 12'sh200,  12'sh100, 1'b0,  500, PER, PER, PER));
        dir_q.push_back(mk(-12'sh200,  12'sh100, 1'b1, 1200, PER, PER, PER));
        dir_q.push_back(mk( 12'sh400,  12'sh400, 1'b0,  100, PER, PER, PER));
        dir_q.push_back(mk( 12'sh400,  12'sh400, 1'b0,   50, PER, PER, 100));
        dir_q.push_back(mk( 12'sh400,  12'sh400, 1'b0,   50, 500, 1000, PER));
        dir_q.push_back(mk( 12'sh400,  12'sh400, 1'b0,   50, PER, PER, PER));
        dir_q.push_back(mk( 12'sh400,  12'sh400, 1'b0,   50, 300, PER, PER));
        dir_q.push_back(mk( 12'sh400,  12'sh400, 1'b0,   50,   0,  10, PER));
        dir_q.push_back(mk(-12'sh0F0,  12'sh400, 1'b0,   50, PER, PER, PER));
        foreach (dir_q[i]) run_period(dir_q[i]);

        for (int k = 0; k < 12; k++) begin
            p.l = 12'($urandom);
            p.r = 12'($urandom);
            case ($urandom % 8)
                0: p.l = 12'sh7FF;
                1: p.l = 12'sh800;
                2: p.r = 12'sh000;
                3: p.r = 12'sh800;
                default: ;
            endcase
            p.decoy = 1'($urandom % 2);
            p.ps = $urandom_range(2, 2040);
            if (!en_prev) begin
                p.pd = 0;
                p.pr = $urandom_range(1, 2000);
            end else if ($urandom % 5 == 0) begin
                p.pd = $urandom_range(0, PER - 1);
                p.pr = ($urandom % 2 == 1) ? $urandom_range(p.pd + 1, PER) : PER;
            end else begin
                p.pd = PER;
                p.pr = PER;
            end
            p.po = ($urandom % 3 == 0) ? $urandom_range(0, PER - 1) : PER;
            run_period(p);
        end

        run_period(mk(12'sh7FF, 12'sh7FF, 1'b0, 10,   0,   1, PER));
        run_period(mk(12'sh7FF, 12'sh7FF, 1'b0, 10, PER, PER, PER));
        ovr_curr = 1'b0;

        @(negedge clk); #1;
        mon_on = 1'b0;
        check("exp_q_left", exp_q.size(), 0);

        // Reset asserted in the middle of a full-duty pulse.
        repeat (100) @(posedge clk);
        #1;
        check("pre_rst lft_fwd", lft_fwd, 1);
        check("pre_rst rght_fwd", rght_fwd, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst lft_fwd", lft_fwd, 0);
        check("async_rst rght_fwd", rght_fwd, 0);
        check("async_rst lft_rev", lft_rev, 0);
        check("async_rst rght_rev", rght_rev, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst prd_tick", prd_tick, 0);
        repeat (PER - 1) @(posedge clk);
        #1;
        check("post_rst tick_at_2047", prd_tick, 1);
        check("post_rst off lft_fwd", lft_fwd, 0);
        check("post_rst off rght_fwd", rght_fwd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mtr_pwm_drv.md
Name: mtr_pwm_drv

Overview:
- Consumes the signed 12-bit wheel speed commands `lft_spd` and `rght_spd` produced by the balance/steer math block.
- Drives the H-bridge gate inputs for both wheel motors with fixed-period PWM: one forward and one reverse leg per motor.
- Provides a dead-time guard, period-synchronous duty update and cycle-by-cycle over-current blanking.
- Sits between the math block and the chip pins.

Parameters:
- PWM_W, 11, width of PWM counter; period = 2^PWM_W clocks.
- DEAD_CYC, 8, clocks at start of every period during which all legs are forced low.
- FLT_CNT, 4, consecutive over-current periods that trip a latched fault (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- lft_spd  in  12  signed left speed command.
- rght_spd  in  12  signed right speed command.
- en  in  1  drive enable (pwr_up from control).
- ovr_curr  in  1  over-current comparator, synchronous to clk.
- lft_fwd  out  1  left forward-leg PWM.
- lft_rev  out  1  left reverse-leg PWM.
- rght_fwd  out  1  right forward-leg PWM.
- rght_rev  out  1  right reverse-leg PWM.
- prd_tick  out  1  one-cycle pulse when cnt == all-ones (last cycle of period).
- fault  out  1  latched over-current fault; constant 0 without the optional feature.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: cnt=0; shadow duties 0; both direction bits 0; state OFF; all PWM outputs 0; prd_tick=0; fault=0; blank=0.
- Counter: cnt is PWM_W bits, free-running in every state, and wraps from 2^PWM_W-1 to 0.
- Command capture: in the cycle where cnt==2^PWM_W-1, each *_spd is registered into a shadow register.
  - Magnitude is |spd|, with -2048 clipped to 2047.
  - Direction bit is spd[11].
  - The new duty applies from cnt==0 of the next period; changes mid-period have no effect until then.
- Leg drive, RUN state only, all outputs registered (1-cycle latency from cnt):
  - Active leg (fwd if dir=0, rev if dir=1) is high when cnt >= DEAD_CYC and cnt < DEAD_CYC+mag and blank==0. The upper bound is computed PWM_W+1 bits wide, so the period end truncates the pulse.
  - Inactive leg is 0.
  - fwd and rev of the same motor are never high in the same cycle.
  - A direction change always crosses a period boundary, so DEAD_CYC low time is guaranteed.
- Zero command: mag=0 gives both legs low for the whole period.
- Blanking: ovr_curr=1 in RUN sets blank from the next cycle. All four legs then go low until cnt wraps to 0, where blank clears. Blanking is global to both motors.
- State machine:
  - OFF: outputs low. Goes to RUN at the first wrap (cnt==2^PWM_W-1) with en=1.
  - RUN: goes to OFF immediately when en=0; outputs are forced low on the next clock edge.
  - FAULT: only exists with the optional feature; outputs low.
- Simultaneous events: en=0 wins over ovr_curr and over command capture. Shadow registers keep updating in OFF, so RUN starts with a fresh command.
- Reset mid-period: all outputs low asynchronously; the counter restarts from 0.

Optional Feature:
- Macro: MTR_PWM_FLT_LATCH_EN.
- With the macro defined:
  - A period counter counts consecutive periods in which blank was set.
  - A period with no blanking clears the counter.
  - Reaching FLT_CNT moves RUN to FAULT at the wrap; fault=1 and all legs are low.
  - FAULT exits to OFF only when en=0, which also clears fault and the counter.
- Without the macro: no FAULT state, fault tied to 0, and over-current only blanks the current period.

Test Plan:
- en=1, lft_spd=+0x100 held -> after first full period, lft_fwd high exactly 256 cycles (cnt 8..263 plus 1-cycle latency), lft_rev always 0, prd_tick every 2048 clocks.
- rght_spd=-0x100 -> rght_rev high 256 cycles/period, rght_fwd 0. rght_spd=0x800 -> rght_rev high 2040 cycles (clipped). lft_spd=0x7FF -> lft_fwd high 2040 cycles.
- lft_spd toggles between +0x200 and -0x200 mid-period -> current period unchanged. Next period uses the new sign, both legs low for cnt 0..7, and fwd/rev never overlap.
- ovr_curr pulsed 1 cycle at cnt=100 with spd=+0x400 -> all legs low from cnt 101 to period end, normal pulse next period, fault stays 0.
- en dropped at cnt=500 -> legs 0 on next edge. en reasserted -> drive resumes only after the next wrap. rst_n asserted mid-pulse -> outputs 0 immediately.
- With MTR_PWM_FLT_LATCH_EN: ovr_curr asserted in 4 consecutive periods -> fault=1 at 4th wrap, outputs held low. ovr_curr then cleared -> fault stays 1 until en=0, which clears it.
